// File: rtl/b13_pkg.sv
// Shared definitions for the b13 serial link: bit timing, frame length and
// receiver state encodings.
package b13_pkg;

  localparam int B13_DELAY_TIME = 104;
  localparam int FRAME_BITS     = 8;

  // 2'b11 is unused; the receiver treats it as IDLE.
  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_DATA = 2'b01,
    RX_STOP = 2'b10
  } rx_state_e;

  // One pulse slot on the line lasts the transmitter delay plus two cycles.
  function automatic int bit_period(input int delay_time);
    return delay_time + 2;
  endfunction

endpackage

// File: rtl/b13_serial_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte with ready/ack out,
// plus status flags.
interface b13_serial_rx_if;

  logic       serial_in;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  modport master (
    output serial_in, rd_ack,
    input  rx_data, data_ready, frame_error, overrun, busy
  );

  modport slave (
    input  serial_in, rd_ack,
    output rx_data, data_ready, frame_error, overrun, busy
  );

endinterface

// File: rtl/b13_rx_bit_timer.sv
// Bit-period timer: counts 0..P-1 while running and flags the last count,
// which is the cycle on which the line is sampled.
module b13_rx_bit_timer
  import b13_pkg::*;
#(
  parameter int DELAY_TIME = B13_DELAY_TIME,
  parameter int CNT_W      = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic sample_tick
);

  localparam int P = bit_period(DELAY_TIME);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

  // The counter never wraps, so it must be able to hold P-1.
  if (P >= (2 ** CNT_W)) begin : g_width_check
    $error("b13_rx_bit_timer: CNT_W too narrow for bit period");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/b13_serial_rx.sv
// b13 serial receiver: recovers MSB-first framed bytes from the transmitter
// pulse line into a one-entry holding register with ready/ack handshake.
module b13_serial_rx
  import b13_pkg::*;
#(
  parameter int DELAY_TIME = B13_DELAY_TIME,
  parameter int CNT_W      = 10
) (
  input logic            clock,
  input logic            reset,
  b13_serial_rx_if.slave rx
);

  rx_state_e  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       data_ready_q, data_ready_d;
  logic       frame_error_q, frame_error_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;
  logic       run, clr, sample_tick, deliver, ack_ok;

  b13_rx_bit_timer #(
    .DELAY_TIME (DELAY_TIME),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .clr         (clr),
    .sample_tick (sample_tick)
  );

  assign run    = (state_q == RX_DATA) || (state_q == RX_STOP);
  assign clr    = (state_q == RX_IDLE);
  assign ack_ok = rx.rd_ack && data_ready_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    data_ready_d  = data_ready_q;
    overrun_d     = overrun_q;
    frame_error_d = 1'b0;
    deliver       = 1'b0;

    // The line idles high between pulses; a low outside a sample slot aborts.
    unique case (state_q)
      RX_IDLE: begin
        if (!rx.serial_in) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (sample_tick) begin
          shift_d   = {shift_q[6:0], rx.serial_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = RX_STOP;
        end else if (!rx.serial_in) begin
          frame_error_d = 1'b1;
          state_d       = RX_IDLE;
        end
      end
      RX_STOP: begin
        if (sample_tick) begin
          deliver       = rx.serial_in;
          frame_error_d = !rx.serial_in;
          state_d       = RX_IDLE;
        end else if (!rx.serial_in) begin
          frame_error_d = 1'b1;
          state_d       = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // An ack in the delivery cycle frees the slot for the new byte.
    if (ack_ok) overrun_d = 1'b0;
    if (deliver) begin
      if (!data_ready_q || rx.rd_ack) begin
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack_ok) begin
      data_ready_d = 1'b0;
    end

    busy_d = (state_q != RX_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      data_ready_q  <= data_ready_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign rx.rx_data     = rx_data_q;
  assign rx.data_ready  = data_ready_q;
  assign rx.frame_error = frame_error_q;
  assign rx.overrun     = overrun_q;
  assign rx.busy        = busy_q;

endmodule

// File: tb/tb_b13_serial_rx.sv
// Directed bench for b13_serial_rx: good frames, bad stop, overrun, ack on
// the stop cycle, spurious low, and reset in mid-frame.
module tb_b13_serial_rx;
  import b13_pkg::*;

  localparam int P = B13_DELAY_TIME + 2;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  b13_serial_rx_if rx_if ();

  b13_serial_rx #(
    .DELAY_TIME (B13_DELAY_TIME),
    .CNT_W      (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives the nine pulse slots after a start edge t0; returns just after
  // edge t0+9P. ack_stop raises rd_ack for the stop-sample edge only.
  task automatic frame_body(input logic [7:0] b, input logic stop_v,
                            input logic ack_stop, input logic strict);
    for (int k = 1; k <= 9; k++) begin
      rx_if.serial_in = 1'b1;
      repeat (P - 1) tick();
      if (strict && k == 9) chk1("ready_before_stop", rx_if.data_ready, 1'b0);
      rx_if.serial_in = (k <= 8) ? b[3'(8 - k)] : stop_v;
      rx_if.rd_ack    = (k == 9) ? ack_stop : 1'b0;
      tick();
      rx_if.rd_ack = 1'b0;
      if (k == 1) begin
        chk1("busy_in_frame", rx_if.busy, 1'b1);
        chk1("no_fe_in_frame", rx_if.frame_error, 1'b0);
      end
    end
    rx_if.serial_in = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop_v,
                           input logic ack_stop, input logic strict);
    rx_if.serial_in = 1'b0;
    tick();
    if (strict) chk1("busy_at_t0", rx_if.busy, 1'b0);
    frame_body(b, stop_v, ack_stop, strict);
  endtask

  task automatic ack();
    rx_if.rd_ack = 1'b1;
    tick();
    rx_if.rd_ack = 1'b0;
  endtask

  initial begin
    rx_if.serial_in = 1'b1;
    rx_if.rd_ack    = 1'b0;
    reset           = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk8("rst_rx_data", rx_if.rx_data, 8'h00);
    chk1("rst_ready", rx_if.data_ready, 1'b0);
    chk1("rst_fe", rx_if.frame_error, 1'b0);
    chk1("rst_overrun", rx_if.overrun, 1'b0);
    chk1("rst_busy", rx_if.busy, 1'b0);
    repeat (5) tick();

    // Good frame 0xA5
    run_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    chk8("a5_data", rx_if.rx_data, 8'hA5);
    chk1("a5_ready", rx_if.data_ready, 1'b1);
    chk1("a5_fe", rx_if.frame_error, 1'b0);
    chk1("a5_busy_last", rx_if.busy, 1'b1);
    tick();
    chk1("a5_busy_after", rx_if.busy, 1'b0);
    chk1("a5_ready_hold", rx_if.data_ready, 1'b1);
    ack();
    chk1("a5_ack_ready", rx_if.data_ready, 1'b0);
    chk8("a5_ack_data", rx_if.rx_data, 8'hA5);
    rx_if.rd_ack = 1'b1;
    tick();
    rx_if.rd_ack = 1'b0;
    chk1("idle_ack_noeffect", rx_if.data_ready, 1'b0);

    // Bad stop bit
    run_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk1("badstop_fe", rx_if.frame_error, 1'b1);
    chk1("badstop_ready", rx_if.data_ready, 1'b0);
    chk8("badstop_data", rx_if.rx_data, 8'hA5);
    tick();
    chk1("badstop_fe_pulse", rx_if.frame_error, 1'b0);

    // Back-to-back without ack -> overrun
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk8("b2b_first", rx_if.rx_data, 8'h3C);
    chk1("b2b_no_ovr", rx_if.overrun, 1'b0);
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    chk8("ovr_data_kept", rx_if.rx_data, 8'h3C);
    chk1("ovr_ready", rx_if.data_ready, 1'b1);
    chk1("ovr_set", rx_if.overrun, 1'b1);
    ack();
    chk1("ovr_ack_ready", rx_if.data_ready, 1'b0);
    chk1("ovr_ack_clear", rx_if.overrun, 1'b0);

    // Ack coincides with the second stop sample
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    run_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    chk8("ackstop_data", rx_if.rx_data, 8'hC3);
    chk1("ackstop_ready", rx_if.data_ready, 1'b1);
    chk1("ackstop_ovr", rx_if.overrun, 1'b0);
    ack();
    chk1("ackstop_clear", rx_if.data_ready, 1'b0);

    // Spurious low at t0+50, restart at t0+52
    rx_if.serial_in = 1'b0;
    tick();
    rx_if.serial_in = 1'b1;
    repeat (49) tick();
    chk1("spur_pre_fe", rx_if.frame_error, 1'b0);
    rx_if.serial_in = 1'b0;
    tick();
    chk1("spur_fe", rx_if.frame_error, 1'b1);
    rx_if.serial_in = 1'b1;
    tick();
    chk1("spur_busy_low", rx_if.busy, 1'b0);
    chk1("spur_fe_pulse", rx_if.frame_error, 1'b0);
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk8("spur_next_data", rx_if.rx_data, 8'h5A);
    chk1("spur_next_ready", rx_if.data_ready, 1'b1);
    chk1("spur_next_fe", rx_if.frame_error, 1'b0);

    // Dropped frame so reset has live flags to clear
    run_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk1("pre_rst_ovr", rx_if.overrun, 1'b1);

    // Reset at t0+300 in the middle of DATA
    rx_if.serial_in = 1'b0;
    tick();
    rx_if.serial_in = 1'b1;
    repeat (211) tick();
    rx_if.serial_in = 1'b0;
    tick();
    rx_if.serial_in = 1'b1;
    repeat (87) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk8("mid_rst_data", rx_if.rx_data, 8'h00);
    chk1("mid_rst_ready", rx_if.data_ready, 1'b0);
    chk1("mid_rst_fe", rx_if.frame_error, 1'b0);
    chk1("mid_rst_ovr", rx_if.overrun, 1'b0);
    chk1("mid_rst_busy", rx_if.busy, 1'b0);
    repeat (17) tick();
    chk1("mid_rst_idle", rx_if.busy, 1'b0);
    // The pulse at t0+318 arrives in IDLE and starts a new frame
    rx_if.serial_in = 1'b0;
    tick();
    frame_body(8'h69, 1'b1, 1'b0, 1'b1);
    chk8("post_rst_data", rx_if.rx_data, 8'h69);
    chk1("post_rst_ready", rx_if.data_ready, 1'b1);
    chk1("post_rst_fe", rx_if.frame_error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
